// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register for the MIPS pipeline.
// A DEPTH-stage shift pipeline carrying the write-back bundle, with stall,
// flush, valid tracking, zero-register write suppression, write-back data
// selection, two forwarding query ports and a registered in-flight counter.
// Stage 0 captures the inputs; stage DEPTH-1 drives the *_out ports.

module mem_wb_pipe_reg #(
  parameter int DATA_W        = 32,
  parameter int REG_W         = 5,
  parameter int DEPTH         = 1,
  parameter int ZERO_SUPPRESS = 1,
  localparam int IF_W         = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [REG_W-1:0]  dest_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              mem_r_en_in,
  input  logic              wb_en_in,
  output logic [REG_W-1:0]  dest_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] pc_out,
  output logic              mem_r_en_out,
  output logic              valid_out,
  output logic              wb_en_out,
  output logic [DATA_W-1:0] wb_data,
  input  logic [REG_W-1:0]  fwd_rs_a,
  input  logic [REG_W-1:0]  fwd_rs_b,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic [IF_W-1:0]   in_flight
);

  localparam int LAST = DEPTH - 1;

  // Stage contents (current)
  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  wb_en_r;
  logic [DEPTH-1:0]  mem_r_en_r;
  logic [REG_W-1:0]  dest_r [DEPTH];
  logic [DATA_W-1:0] alu_r  [DEPTH];
  logic [DATA_W-1:0] mem_r  [DEPTH];
  logic [DATA_W-1:0] pc_r   [DEPTH];

  // Stage contents (next)
  logic [DEPTH-1:0]  valid_nxt_s;
  logic [DEPTH-1:0]  wb_en_nxt_s;
  logic [DEPTH-1:0]  mem_r_en_nxt_s;
  logic [REG_W-1:0]  dest_nxt_s [DEPTH];
  logic [DATA_W-1:0] alu_nxt_s  [DEPTH];
  logic [DATA_W-1:0] mem_nxt_s  [DEPTH];
  logic [DATA_W-1:0] pc_nxt_s   [DEPTH];

  logic [IF_W-1:0]   in_flight_r;
  logic [IF_W-1:0]   count_nxt_s;

  // Per-stage derived values
  logic [DATA_W-1:0] wb_val_s [DEPTH];
  logic [DEPTH-1:0]  match_a_s;
  logic [DEPTH-1:0]  match_b_s;
  logic              fwd_hit_a_s;
  logic              fwd_hit_b_s;
  logic [DATA_W-1:0] fwd_data_a_s;
  logic [DATA_W-1:0] fwd_data_b_s;

  // A register index may be written/forwarded unless it is r0 with suppression on.
  function automatic logic reg_writable(input logic [REG_W-1:0] idx);
    return (idx != {REG_W{1'b0}}) || (ZERO_SUPPRESS == 0);
  endfunction

  // Next-state: flush beats stall; otherwise shift, capturing a bubble for invalid input.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      valid_nxt_s[k]    = valid_r[k];
      wb_en_nxt_s[k]    = wb_en_r[k];
      mem_r_en_nxt_s[k] = mem_r_en_r[k];
      dest_nxt_s[k]     = dest_r[k];
      alu_nxt_s[k]      = alu_r[k];
      mem_nxt_s[k]      = mem_r[k];
      pc_nxt_s[k]       = pc_r[k];
    end
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_nxt_s[k]    = 1'b0;
        wb_en_nxt_s[k]    = 1'b0;
        mem_r_en_nxt_s[k] = 1'b0;
        dest_nxt_s[k]     = {REG_W{1'b0}};
        alu_nxt_s[k]      = {DATA_W{1'b0}};
        mem_nxt_s[k]      = {DATA_W{1'b0}};
        pc_nxt_s[k]       = {DATA_W{1'b0}};
      end
    end else if (stall) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_nxt_s[k]    = valid_r[k];
        wb_en_nxt_s[k]    = wb_en_r[k];
        mem_r_en_nxt_s[k] = mem_r_en_r[k];
        dest_nxt_s[k]     = dest_r[k];
        alu_nxt_s[k]      = alu_r[k];
        mem_nxt_s[k]      = mem_r[k];
        pc_nxt_s[k]       = pc_r[k];
      end
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        valid_nxt_s[k]    = valid_r[k-1];
        wb_en_nxt_s[k]    = wb_en_r[k-1];
        mem_r_en_nxt_s[k] = mem_r_en_r[k-1];
        dest_nxt_s[k]     = dest_r[k-1];
        alu_nxt_s[k]      = alu_r[k-1];
        mem_nxt_s[k]      = mem_r[k-1];
        pc_nxt_s[k]       = pc_r[k-1];
      end
      if (in_valid) begin
        valid_nxt_s[0]    = 1'b1;
        wb_en_nxt_s[0]    = wb_en_in;
        mem_r_en_nxt_s[0] = mem_r_en_in;
        dest_nxt_s[0]     = dest_in;
        alu_nxt_s[0]      = alu_result_in;
        mem_nxt_s[0]      = mem_data_in;
        pc_nxt_s[0]       = pc_in;
      end else begin
        valid_nxt_s[0]    = 1'b0;
        wb_en_nxt_s[0]    = 1'b0;
        mem_r_en_nxt_s[0] = 1'b0;
        dest_nxt_s[0]     = {REG_W{1'b0}};
        alu_nxt_s[0]      = {DATA_W{1'b0}};
        mem_nxt_s[0]      = {DATA_W{1'b0}};
        pc_nxt_s[0]       = {DATA_W{1'b0}};
      end
    end
  end

  // Population count of the next valid bits feeds the registered in-flight counter.
  always_comb begin
    count_nxt_s = {IF_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      count_nxt_s = count_nxt_s + IF_W'(valid_nxt_s[k]);
    end
  end

  // Stage registers and in-flight counter, cleared immediately by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r     <= {DEPTH{1'b0}};
      wb_en_r     <= {DEPTH{1'b0}};
      mem_r_en_r  <= {DEPTH{1'b0}};
      in_flight_r <= {IF_W{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        dest_r[k] <= {REG_W{1'b0}};
        alu_r[k]  <= {DATA_W{1'b0}};
        mem_r[k]  <= {DATA_W{1'b0}};
        pc_r[k]   <= {DATA_W{1'b0}};
      end
    end else begin
      valid_r     <= valid_nxt_s;
      wb_en_r     <= wb_en_nxt_s;
      mem_r_en_r  <= mem_r_en_nxt_s;
      in_flight_r <= count_nxt_s;
      for (int k = 0; k < DEPTH; k++) begin
        dest_r[k] <= dest_nxt_s[k];
        alu_r[k]  <= alu_nxt_s[k];
        mem_r[k]  <= mem_nxt_s[k];
        pc_r[k]   <= pc_nxt_s[k];
      end
    end
  end

  // Per-stage write-back value and forwarding match vectors.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      wb_val_s[k]  = {DATA_W{1'b0}};
      match_a_s[k] = 1'b0;
      match_b_s[k] = 1'b0;
      if (valid_r[k]) begin
        wb_val_s[k] = mem_r_en_r[k] ? mem_r[k] : alu_r[k];
      end else begin
        wb_val_s[k] = {DATA_W{1'b0}};
      end
      match_a_s[k] = valid_r[k] & wb_en_r[k] & (dest_r[k] == fwd_rs_a) & reg_writable(fwd_rs_a);
      match_b_s[k] = valid_r[k] & wb_en_r[k] & (dest_r[k] == fwd_rs_b) & reg_writable(fwd_rs_b);
    end
  end

  // Forward select: scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    fwd_hit_a_s  = |match_a_s;
    fwd_hit_b_s  = |match_b_s;
    fwd_data_a_s = {DATA_W{1'b0}};
    fwd_data_b_s = {DATA_W{1'b0}};
    for (int k = DEPTH - 1; k >= 0; k--) begin
      fwd_data_a_s = match_a_s[k] ? wb_val_s[k] : fwd_data_a_s;
      fwd_data_b_s = match_b_s[k] ? wb_val_s[k] : fwd_data_b_s;
    end
  end

  assign dest_out       = dest_r[LAST];
  assign alu_result_out = alu_r[LAST];
  assign mem_data_out   = mem_r[LAST];
  assign pc_out         = pc_r[LAST];
  assign mem_r_en_out   = mem_r_en_r[LAST];
  assign valid_out      = valid_r[LAST];
  assign wb_en_out      = valid_r[LAST] & wb_en_r[LAST] & reg_writable(dest_r[LAST]);
  assign wb_data        = wb_val_s[LAST];
  assign fwd_hit_a      = fwd_hit_a_s;
  assign fwd_hit_b      = fwd_hit_b_s;
  assign fwd_data_a     = fwd_data_a_s;
  assign fwd_data_b     = fwd_data_b_s;
  assign in_flight      = in_flight_r;

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
- Parametrised MEM→WB pipeline register for the MIPS pipeline.
- It is a DEPTH-stage shift pipeline carrying the write-back bundle: dest, alu_result, mem_data, pc, mem_r_en, wb_en and valid.
- Adds stall, flush, valid tracking, zero-register write suppression, a write-back data mux, two forwarding query ports and an in-flight counter.
- DEPTH>1 models multi-cycle data memory latency.

Parameters:
- DATA_W, 32, width of alu_result, mem_data, pc and wb_data.
- REG_W, 5, register index width.
- DEPTH, 1, number of register stages (1..8).
- ZERO_SUPPRESS, 1, when 1 a write to register 0 never asserts wb_en_out.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold all stages.
- flush  in  1  invalidate all stages and the incoming bundle.
- in_valid  in  1  incoming bundle is a real instruction.
- dest_in  in  REG_W  destination register.
- alu_result_in  in  DATA_W  ALU result.
- mem_data_in  in  DATA_W  data memory read value.
- pc_in  in  DATA_W  instruction PC.
- mem_r_en_in  in  1  instruction is a load.
- wb_en_in  in  1  instruction writes the register file.
- dest_out  out  REG_W  last-stage dest.
- alu_result_out  out  DATA_W  last-stage ALU result.
- mem_data_out  out  DATA_W  last-stage memory data.
- pc_out  out  DATA_W  last-stage PC.
- mem_r_en_out  out  1  last-stage load flag.
- valid_out  out  1  last stage holds a valid instruction.
- wb_en_out  out  1  effective register-file write enable.
- wb_data  out  DATA_W  selected write-back value.
- fwd_rs_a, fwd_rs_b  in  REG_W  forwarding query registers.
- fwd_hit_a, fwd_hit_b  out  1  query matches an in-flight writer.
- fwd_data_a, fwd_data_b  out  DATA_W  forwarded value.
- in_flight  out  clog2(DEPTH+1)  count of valid stages.

Behaviour:
- Reset (async, immediate): all stage fields, valid bits and in_flight = 0. All outputs therefore read 0.
- Stage numbering: stage 0 captures the inputs, stage DEPTH-1 drives the *_out ports. Latency is DEPTH cycles when stall=0.
- Normal edge (stall=0, flush=0):
  - stage0 <= inputs, with valid = in_valid.
  - stage k <= stage k-1 for k=1..DEPTH-1.
- Stall edge (stall=1, flush=0): every stage holds all fields. Inputs are ignored and must be held by the upstream stage.
- Flush edge (flush=1): every stage, including the one capturing the inputs, becomes a bubble. Flush has priority over stall.
- Bubble definition: valid=0, wb_en=0, mem_r_en=0, dest=0, and all data/pc fields = 0.
- Invalid input (in_valid=0, no flush): captured as a bubble, not as raw data.
- Outputs (combinational from the last stage):
  - wb_en_out = valid & wb_en & (dest≠0 or ZERO_SUPPRESS=0).
  - wb_data = mem_r_en ? mem_data : alu_result. A bubble gives 0.
- Forwarding (combinational, evaluated for each port independently):
  - Stage k matches when valid_k & wb_en_k & dest_k==fwd_rs & (fwd_rs≠0 or ZERO_SUPPRESS=0).
  - fwd_hit = OR of all stage matches.
  - fwd_data = the selected wb value of the lowest-index (youngest) matching stage; 0 when there is no hit.
  - Forwarding does not look at the live inputs.
- in_flight: registered. It equals the number of valid stages after each edge, and is 0 after a flush or reset.
- DEPTH=1: one register stage with stall, flush and valid behaviour. Forwarding and in_flight cover that single stage.

Test Plan:
- Reset mid-stream: DEPTH=3, rst asserted between clock edges → all outputs 0 immediately and in_flight=0. The first valid bundle after release appears at valid_out on the 3rd edge.
- Latency/mux: DEPTH=2, inputs dest=7, alu=0x10, mem=0xAA, mem_r_en=1, wb_en=1 → after 2 edges wb_data=0xAA and wb_en_out=1. Same test with mem_r_en=0 → wb_data=0x10.
- Stall then flush: fill DEPTH=3 with three valid bundles, hold stall=1 for 4 edges → outputs unchanged and in_flight=3. Then assert flush together with stall → next edge valid_out=0, wb_en_out=0, in_flight=0.
- Zero register: dest=0, wb_en=1, ZERO_SUPPRESS=1 → wb_en_out=0 and a fwd_rs_a=0 query does not hit. Same test with ZERO_SUPPRESS=0 → wb_en_out=1.
- Forward priority: DEPTH=3, stage0 dest=5 alu=0x22, stage2 dest=5 alu=0x11, fwd_rs_a=5 → fwd_hit_a=1, fwd_data_a=0x22. fwd_rs_b=9 with no writer → fwd_hit_b=0, fwd_data_b=0.
- Bubble insertion: in_valid=0 with nonzero data inputs → that slot arrives with valid_out=0, wb_data=0 and pc_out=0.
